// File: rtl/eth_pkg.sv
// Shared constants and state type for the GMII receive path.
// No ports; imported by the eth_rx_frame files and the TX FCS path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP,
    DROP_RPT,
    DONE
  } rx_state_t;

endpackage

// File: rtl/eth_rx_frame_if.sv
// Packet-buffer word write bus: wr strobe, word address, packed data.
// master = receive stage (drives), slave = packet buffer (consumes).
interface eth_rx_frame_if #(
  parameter int ADDR_W = 9
);

  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;

  modport master (output wr, addr, data);
  modport slave  (input  wr, addr, data);

endinterface

// File: rtl/eth_crc32_d8.sv
// Combinational CRC32 (reflected 0xEDB88320) advance by one byte, LSB first.
// Ports: i_crc current register, i_data byte, o_crc next register.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] w_c;
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      if (w_c[0]) w_c = (w_c >> 1) ^ CRC_POLY;
      else        w_c = w_c >> 1;
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/eth_rx_frame.sv
// GMII RX frame stage: strips preamble/SFD, checks FCS, packs words.
// Ports: i_rx_clk/rst_n, GMII i_rx_dv/i_rx_data, o_buf write bus, status, irq/ack, drop count.
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter int MAX_BYTES = 1518,
  parameter int MIN_BYTES = 64,
  parameter int ADDR_W    = 9
) (
  input  logic           i_rx_clk,
  input  logic           rst_n,
  input  logic           i_rx_dv,
  input  logic [7:0]     i_rx_data,
  eth_rx_frame_if.master o_buf,
  output logic [10:0]    o_pkt_len,
  output logic           o_pkt_crc_ok,
  output logic           o_pkt_runt,
  output logic           o_pkt_oversize,
  output logic           o_irq_rx,
  input  logic           i_pkt_ack,
  output logic [15:0]    o_drop_cnt
);

  localparam logic [10:0] L_MAX = 11'(MAX_BYTES);
  localparam logic [10:0] L_MIN = 11'(MIN_BYTES);

  rx_state_t         r_state;
  rx_state_t         w_next;

  logic [10:0]       r_cnt;
  logic [31:0]       r_crc;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic              r_dv_d;

  logic              r_buf_wr;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [31:0]       r_buf_data;

  logic [10:0]       r_len;
  logic              r_crc_ok;
  logic              r_runt;
  logic              r_ovs;
  logic              r_irq;
  logic [15:0]       r_drop_cnt;

  logic [31:0]       w_crc_nxt;
  logic              w_sfd;
  logic              w_take;
  logic              w_ovf;
  logic              w_end;
  logic              w_rpt;
  logic              w_ack;
  logic              w_flush;
  logic              w_dv_rise;

  eth_crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (i_rx_data),
    .o_crc  (w_crc_nxt)
  );

  always_ff @(posedge i_rx_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_sfd  = 1'b0;
    w_take = 1'b0;
    w_ovf  = 1'b0;
    w_end  = 1'b0;
    w_rpt  = 1'b0;
    w_ack  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_data == ETH_PREAMBLE) w_next = PREAMBLE;
          else                           w_next = DROP;
        end
      end
      PREAMBLE: begin
        if (!i_rx_dv) begin
          w_next = IDLE;
        end else if (i_rx_data == ETH_SFD) begin
          w_next = DATA;
          w_sfd  = 1'b1;
        end else if (i_rx_data != ETH_PREAMBLE) begin
          w_next = DROP;
        end
      end
      DATA: begin
        if (!i_rx_dv) begin
          w_end  = 1'b1;
          w_next = DONE;
        end else if (r_cnt == L_MAX) begin
          w_ovf  = 1'b1;
          w_next = DROP_RPT;
        end else begin
          w_take = 1'b1;
        end
      end
      DROP_RPT: begin
        if (!i_rx_dv) begin
          w_rpt  = 1'b1;
          w_next = DONE;
        end
      end
      DROP: begin
        if (!i_rx_dv) w_next = IDLE;
      end
      DONE: begin
        if (i_pkt_ack) begin
          w_ack  = 1'b1;
          w_next = i_rx_dv ? DROP : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Leftover bytes of a partial word go out on frame end or overflow.
  assign w_flush   = (w_end | w_ovf) & (r_cnt[1:0] != 2'd0);
  assign w_dv_rise = i_rx_dv & ~r_dv_d;

  always_ff @(posedge i_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_crc      <= CRC_INIT;
      r_word     <= '0;
      r_addr     <= '0;
      r_dv_d     <= 1'b0;
      r_buf_wr   <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_len      <= '0;
      r_crc_ok   <= 1'b0;
      r_runt     <= 1'b0;
      r_ovs      <= 1'b0;
      r_irq      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_dv_d   <= i_rx_dv;
      r_buf_wr <= 1'b0;
      if (w_sfd) begin
        r_cnt  <= '0;
        r_crc  <= CRC_INIT;
        r_word <= '0;
        r_addr <= '0;
      end
      if (w_take) begin
        r_crc <= w_crc_nxt;
        r_cnt <= r_cnt + 11'd1;
        if (r_cnt[1:0] == 2'd3) begin
          r_buf_wr   <= 1'b1;
          r_buf_addr <= r_addr;
          r_buf_data <= {i_rx_data, r_word[23:0]};
          r_addr     <= r_addr + 1'b1;
          r_word     <= '0;
        end else begin
          r_word[{r_cnt[1:0], 3'b000} +: 8] <= i_rx_data;
        end
      end
      if (w_flush) begin
        r_buf_wr   <= 1'b1;
        r_buf_addr <= r_addr;
        r_buf_data <= r_word;
      end
      if (w_end) begin
        r_len    <= r_cnt;
        r_crc_ok <= (r_crc == CRC_RESIDUE);
        r_runt   <= (r_cnt < L_MIN);
        r_ovs    <= 1'b0;
        r_irq    <= 1'b1;
      end
      if (w_rpt) begin
        r_len    <= L_MAX;
        r_crc_ok <= 1'b0;
        r_runt   <= (L_MAX < L_MIN);
        r_ovs    <= 1'b1;
        r_irq    <= 1'b1;
      end
      if (w_ack) begin
        r_len    <= '0;
        r_crc_ok <= 1'b0;
        r_runt   <= 1'b0;
        r_ovs    <= 1'b0;
        r_irq    <= 1'b0;
      end
      // One count per frame start seen while the buffer is owned.
      if (r_state == DONE && w_dv_rise && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_buf.wr       = r_buf_wr;
  assign o_buf.addr     = r_buf_addr;
  assign o_buf.data     = r_buf_data;
  assign o_pkt_len      = r_len;
  assign o_pkt_crc_ok   = r_crc_ok;
  assign o_pkt_runt     = r_runt;
  assign o_pkt_oversize = r_ovs;
  assign o_irq_rx       = r_irq;
  assign o_drop_cnt     = r_drop_cnt;

endmodule
